// File: rtl/exibe_sequencia_pkg.sv
// Shared definitions for the LED sequence playback block.
package exibe_sequencia_pkg;

    localparam int ADDR_W = 4;
    localparam int DADO_W = 4;

    // Playback states; the encoding is exported on db_estado for debug.
    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        BUSCA   = 4'd1,
        CARREGA = 4'd2,
        ACENDE  = 4'd3,
        APAGA   = 4'd4,
        FIM     = 4'd5
    } estado_t;

endpackage

// File: rtl/exibe_sequencia_if.sv
// Control, ROM and LED signals of the sequence playback block.
interface exibe_sequencia_if;
    import exibe_sequencia_pkg::*;

    logic              iniciar;
    logic [ADDR_W-1:0] limite;
    logic [ADDR_W-1:0] rom_endereco;
    logic [DADO_W-1:0] rom_dado;
    logic [DADO_W-1:0] leds;
    logic              ocupado;
    logic              pronto;
    logic [3:0]        db_estado;

    // Control unit / ROM side.
    modport master (
        output iniciar, limite, rom_dado,
        input  rom_endereco, leds, ocupado, pronto, db_estado
    );

    // Playback block side.
    modport slave (
        input  iniciar, limite, rom_dado,
        output rom_endereco, leds, ocupado, pronto, db_estado
    );

endinterface

// File: rtl/exibe_sequencia_temporizador_carga.sv
// Loadable down-counter; fim flags a count of zero.
module temporizador_carga #(
    parameter int W = 9
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         carrega,
    input  logic [W-1:0] valor,
    output logic         fim
);

    logic [W-1:0] r_conta;

    // Load takes priority; otherwise count down and rest at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_conta <= '0;
        end else if (carrega) begin
            r_conta <= valor;
        end else if (r_conta != '0) begin
            r_conta <= r_conta - W'(1);
        end
    end

    assign fim = (r_conta == '0);

endmodule

// File: rtl/exibe_sequencia.sv
// Plays ROM entries 0..limite on the LEDs: each entry lit for ON_CYCLES,
// then dark for OFF_CYCLES, with a one-cycle pronto pulse at the end.
module exibe_sequencia
    import exibe_sequencia_pkg::*;
#(
    parameter int ON_CYCLES  = 500,
    parameter int OFF_CYCLES = 250
) (
    input  logic             clock,
    input  logic             reset,
    exibe_sequencia_if.slave bus
);

    localparam int MAX_CICLOS = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW         = (MAX_CICLOS <= 1) ? 1 : $clog2(MAX_CICLOS);
    localparam logic [TW-1:0] CARGA_ON  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] CARGA_OFF = TW'(OFF_CYCLES - 1);

    estado_t           r_estado;
    logic [ADDR_W-1:0] r_endereco;
    logic [ADDR_W-1:0] r_limite;
    logic [DADO_W-1:0] r_leds;
    logic              r_ocupado;
    logic              r_pronto;

    logic              w_fim;
    logic              w_carrega;
    logic [TW-1:0]     w_valor;

    // One timer serves both the lit and the dark phase: it is loaded with the
    // ON time when leaving CARREGA and with the OFF time when ACENDE expires.
    assign w_carrega = (r_estado == CARREGA) || ((r_estado == ACENDE) && w_fim);
    assign w_valor   = (r_estado == CARREGA) ? CARGA_ON : CARGA_OFF;

    temporizador_carga #(
        .W(TW)
    ) u_temporizador (
        .clock   (clock),
        .reset   (reset),
        .carrega (w_carrega),
        .valor   (w_valor),
        .fim     (w_fim)
    );

    // Playback FSM with registered address, LEDs and status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= OCIOSO;
            r_endereco <= '0;
            r_limite   <= '0;
            r_leds     <= '0;
            r_ocupado  <= 1'b0;
            r_pronto   <= 1'b0;
        end else begin
            r_pronto <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    r_leds <= '0;
                    if (bus.iniciar) begin
                        r_limite   <= bus.limite;
                        r_endereco <= '0;
                        r_ocupado  <= 1'b1;
                        r_estado   <= BUSCA;
                    end else begin
                        r_ocupado <= 1'b0;
                    end
                end
                // Address is stable this cycle; the ROM samples it at the edge.
                BUSCA: begin
                    r_estado <= CARREGA;
                end
                CARREGA: begin
                    r_leds   <= bus.rom_dado;
                    r_estado <= ACENDE;
                end
                ACENDE: begin
                    if (w_fim) begin
                        r_leds   <= '0;
                        r_estado <= APAGA;
                    end
                end
                // Compare before incrementing so the address never wraps past 15.
                APAGA: begin
                    if (w_fim) begin
                        if (r_endereco == r_limite) begin
                            r_pronto <= 1'b1;
                            r_estado <= FIM;
                        end else begin
                            r_endereco <= r_endereco + ADDR_W'(1);
                            r_estado   <= BUSCA;
                        end
                    end
                end
                FIM: begin
                    r_ocupado <= 1'b0;
                    r_estado  <= OCIOSO;
                end
                default: begin
                    r_leds    <= '0;
                    r_ocupado <= 1'b0;
                    r_estado  <= OCIOSO;
                end
            endcase
        end
    end

    assign bus.rom_endereco = r_endereco;
    assign bus.leds         = r_leds;
    assign bus.ocupado      = r_ocupado;
    assign bus.pronto       = r_pronto;
    assign bus.db_estado    = r_estado;

endmodule

// File: doc/exibe_sequencia.md
Name: exibe_sequencia

Overview:
- Plays the stored game sequence back to the player on the LEDs. It is the output-side counterpart of the datapath that reads button presses and compares them against the ROM.
- It reads the same 16x4 synchronous ROM image, from address 0 up to a latched limit. Each entry is lit for a fixed time, then a blank gap follows.
- It sits beside fluxo_dados and is started by the game's control unit before each round.

Parameters:
- ON_CYCLES, 500, clock cycles each entry stays lit (0.5 s at 1 kHz); must be >= 1
- OFF_CYCLES, 250, clock cycles of blank gap after each entry; must be >= 1

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- iniciar  in  1  start request; sampled only in OCIOSO
- limite  in  4  last address to display (sequence length minus 1); latched at start
- rom_endereco  out  4  address to the sync ROM (registered)
- rom_dado  in  4  ROM data; valid one cycle after the address changes
- leds  out  4  LED pattern (registered)
- ocupado  out  1  high in every state except OCIOSO
- pronto  out  1  one-cycle pulse when playback completes
- db_estado  out  4  current state encoding, for debug

Behaviour:
- Reset is synchronous and active-high. Outputs in reset:
  - state = OCIOSO
  - rom_endereco = 0, leds = 0
  - pronto = 0, ocupado = 0
  - timer cleared, latched limit = 0
- Reset asserted mid-playback returns the block to OCIOSO on the next edge, with the same values. No pronto pulse is issued.
- States and encodings (db_estado):
  - OCIOSO = 0
  - BUSCA = 1
  - CARREGA = 2
  - ACENDE = 3
  - APAGA = 4
  - FIM = 5
- OCIOSO:
  - leds = 0.
  - If iniciar = 1 at edge k: latch limite, set rom_endereco = 0, go to BUSCA.
- BUSCA: lasts 1 cycle. The ROM samples the address. Go to CARREGA.
- CARREGA: lasts 1 cycle; rom_dado is valid. On exit, leds <= rom_dado and the timer loads ON_CYCLES-1. Go to ACENDE.
- ACENDE:
  - Lasts exactly ON_CYCLES cycles; leds hold the value.
  - On expiry: leds <= 0, timer loads OFF_CYCLES-1, go to APAGA.
- APAGA: lasts exactly OFF_CYCLES cycles with leds = 0. On expiry:
  - if rom_endereco == latched limit: go to FIM
  - else: rom_endereco increments, go to BUSCA
- FIM: lasts 1 cycle, with pronto = 1 and ocupado = 1. Go to OCIOSO.
- Latency: with iniciar sampled at edge k, leds first show entry 0 at cycle k+3.
- Period per entry: 2 + ON_CYCLES + OFF_CYCLES cycles.
- Total busy time: (limite+1)*(2+ON_CYCLES+OFF_CYCLES) + 1 cycles.
- iniciar while ocupado = 1 is ignored (no restart, no queueing).
- iniciar held high across FIM: a new playback starts from OCIOSO on the following edge.
- Changes on limite during playback are ignored; the latched copy is used.
- limite = 15 plays all 16 entries. rom_endereco never wraps past 15, because the compare stops at 15 before any increment.
- A ROM entry of 0 still consumes a full ACENDE period (LEDs dark); timing does not change.
- Timer width: enough bits for max(ON_CYCLES, OFF_CYCLES) - 1. It counts down and expires at 0.

Decomposition:
- Shared package holds:
  - state encoding localparams (OCIOSO..FIM, 4-bit)
  - ROM address width (4) and data width (4)
- Sub-module temporizador_carga: a loadable down-counter.
  - Ports: clock, reset, carrega, valor, fim.
  - fim is combinational, high when count = 0.
  - Instantiated once and shared between ACENDE and APAGA.
- ROM is external. Connect sync_rom_16x4 at the top level, not inside this block.

Test Plan:
- Parameters for all scenarios: ON_CYCLES = 3, OFF_CYCLES = 2; ROM model with 1-cycle latency, contents 1,2,4,8,...
- Reset: assert reset for 2 cycles mid-ACENDE -> next cycle state = 0, leds = 0, rom_endereco = 0, ocupado = 0, pronto never pulses.
- Single entry: limite = 0, pulse iniciar at edge k ->
  - leds = 1 on cycles k+3..k+5
  - leds = 0 on cycles k+6..k+7
  - pronto = 1 only at k+8
  - ocupado low at k+9
- Full sequence: limite = 3 ->
  - leds show 1, 2, 4, 8, each 3 cycles, with a 2-cycle gap between
  - rom_endereco steps 0..3
  - pronto asserted exactly 29 cycles after start
- Ignore restart: pulse iniciar again during entry 2 and change limite to 0 mid-run -> playback continues to address 3 unchanged, exactly one pronto.
- Boundary: limite = 15, ROM word 5 = 0 ->
  - 16 entries shown
  - address 5 dark for 3 cycles
  - rom_endereco stops at 15 with no wrap
  - pronto after 113 cycles
- Back-to-back: iniciar held high continuously -> after pronto, OCIOSO lasts one cycle, then BUSCA restarts at address 0.
